// File: rtl/cu_pkg.sv
// Shared control-unit types: FSM states, opcodes and ALU selects.
// ALU select values are also consumed by the 12-bit ALU.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_EXEC,
    S_MEMWAIT,
    S_OPFETCH,
    S_OPLATCH,
    S_END
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDAC  = 8'h01;
  localparam logic [7:0] OP_STAC  = 8'h02;
  localparam logic [7:0] OP_CLAC  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h04;
  localparam logic [7:0] OP_SUB   = 8'h05;
  localparam logic [7:0] OP_MUL   = 8'h06;
  localparam logic [7:0] OP_INCAC = 8'h07;
  localparam logic [7:0] OP_MVACR = 8'h08;
  localparam logic [7:0] OP_JUMP  = 8'h09;
  localparam logic [7:0] OP_JPNZ  = 8'h0A;
  localparam logic [7:0] OP_ENDOP = 8'h0B;

  localparam logic [2:0] ALU_CLR  = 3'd0;
  localparam logic [2:0] ALU_PASS = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_MUL  = 3'd4;
  localparam logic [2:0] ALU_INC  = 3'd5;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       ac_write;
    logic       r_write;
    logic       imem_read;
    logic       dmem_read;
    logic       dmem_write;
    logic       busy;
    logic       done;
  } ctrl_t;

  function automatic logic is_jump(input logic [7:0] op);
    return (op == OP_JUMP) || (op == OP_JPNZ);
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Moore output decode: state + IR -> ALU select and strobes.
// last is low only on a stretched MUL's first EXEC cycle.
import cu_pkg::*;

module cu_decoder (
  input  state_t     state,
  input  logic [7:0] ir,
  input  logic       last,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_PASS;
    ctrl.busy   = (state != S_IDLE) && (state != S_END);
    unique case (state)
      S_FETCH, S_OPFETCH: ctrl.imem_read = 1'b1;
      S_EXEC: begin
        case (ir)
          OP_CLAC: begin
            ctrl.alu_op   = ALU_CLR;
            ctrl.ac_write = 1'b1;
          end
          OP_ADD: begin
            ctrl.alu_op   = ALU_ADD;
            ctrl.ac_write = 1'b1;
          end
          OP_SUB: begin
            ctrl.alu_op   = ALU_SUB;
            ctrl.ac_write = 1'b1;
          end
          OP_MUL: begin
            ctrl.alu_op   = ALU_MUL;
            ctrl.ac_write = last;
          end
          OP_INCAC: begin
            ctrl.alu_op   = ALU_INC;
            ctrl.ac_write = 1'b1;
          end
          OP_LDAC:  ctrl.dmem_read  = 1'b1;
          OP_STAC:  ctrl.dmem_write = 1'b1;
          OP_MVACR: ctrl.r_write    = 1'b1;
          default: ;
        endcase
      end
      S_MEMWAIT: ctrl.ac_write = 1'b1;
      S_END:     ctrl.done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Per-core sequencer: fetch/decode FSM and PC in front of the ALU.
// Define CU_MUL_WAIT_EN to give MUL a second EXEC cycle.
import cu_pkg::*;

module control_unit #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          instrIn,
  input  logic                zFlag,
  output logic [2:0]          aluOp,
  output logic                acWrite,
  output logic                rWrite,
  output logic                imemRead,
  output logic                dmemRead,
  output logic                dmemWrite,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic                busy,
  output logic                done
);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic                last;
  ctrl_t               ctrl;

`ifdef CU_MUL_WAIT_EN
  logic mul_hold;

  assign last = !((ir == OP_MUL) && !mul_hold);

  always_ff @(posedge clk) begin
    if (rst)
      mul_hold <= 1'b0;
    else if ((state == S_EXEC) && (ir == OP_MUL))
      mul_hold <= !mul_hold;
    else
      mul_hold <= 1'b0;
  end
`else
  assign last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          ir    <= instrIn;
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (ir == OP_ENDOP)
            state <= S_END;
          else if (is_jump(ir))
            state <= S_OPFETCH;
          else
            state <= S_EXEC;
        end
        S_EXEC: begin
          if (last)
            state <= (ir == OP_LDAC) ? S_MEMWAIT : S_FETCH;
        end
        S_MEMWAIT: state <= S_FETCH;
        S_OPFETCH: state <= S_OPLATCH;
        S_OPLATCH: begin
          if ((ir == OP_JUMP) || !zFlag)
            pc <= instrIn[PC_WIDTH-1:0];
          else
            pc <= pc + 1'b1;
          state <= S_FETCH;
        end
        S_END: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  cu_decoder u_dec (
    .state (state),
    .ir    (ir),
    .last  (last),
    .ctrl  (ctrl)
  );

  assign aluOp     = ctrl.alu_op;
  assign acWrite   = ctrl.ac_write;
  assign rWrite    = ctrl.r_write;
  assign imemRead  = ctrl.imem_read;
  assign dmemRead  = ctrl.dmem_read;
  assign dmemWrite = ctrl.dmem_write;
  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign pcOut     = pc;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table plus random
// programs against an instruction-level expected-trace model.
module tb_control_unit;

  typedef logic [17:0] vec_t;

  typedef struct {
    string      name;
    logic [7:0] p0;
    logic [7:0] p1;
    bit         z;
    int         cyc;
    vec_t       e;
  } row_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] instrIn;
  logic       zFlag;
  logic [2:0] aluOp;
  logic       acWrite, rWrite, imemRead, dmemRead, dmemWrite;
  logic [7:0] pcOut;
  logic       busy, done;

  logic [7:0] mem[256];
  logic [7:0] raddr;
  bit         zseq[512];
  vec_t       got[512];
  vec_t       exp_q[$];
  row_t       tbl[$];
  int         nchk;
  int         nerr;

  control_unit #(.PC_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .instrIn   (instrIn),
    .zFlag     (zFlag),
    .aluOp     (aluOp),
    .acWrite   (acWrite),
    .rWrite    (rWrite),
    .imemRead  (imemRead),
    .dmemRead  (dmemRead),
    .dmemWrite (dmemWrite),
    .pcOut     (pcOut),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data returned the cycle after the read strobe.
  initial raddr = 8'h00;
  always @(posedge clk) if (imemRead) raddr <= pcOut;
  assign instrIn = mem[raddr];

  function automatic vec_t pk(input logic [2:0] a, input logic acw,
                              input logic rw, input logic imr,
                              input logic dmr, input logic dmw,
                              input logic bz, input logic dn,
                              input logic [7:0] p);
    return {a, acw, rw, imr, dmr, dmw, bz, dn, p};
  endfunction

  function automatic vec_t cur();
    return {aluOp, acWrite, rWrite, imemRead, dmemRead, dmemWrite,
            busy, done, pcOut};
  endfunction

  function automatic void check(input string name, input vec_t g,
                                input vec_t e);
    nchk++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s got=%05h (alu=%0d pc=%02h) exp=%05h (alu=%0d pc=%02h)",
               name, g, g[17:15], g[7:0], e, e[17:15], e[7:0]);
    end
  endfunction

  function automatic void fill_end();
    for (int i = 0; i < 256; i++) mem[i] = 8'h0B;
  endfunction

  // Expands the program instruction by instruction into the
  // expected per-cycle outputs, cycle 0 being the first fetch.
  task automatic build_model(input int cap);
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] tgt;
    bit         fin;
    bit         z;
    pc  = 8'h00;
    fin = 1'b0;
    exp_q.delete();
    while (!fin && exp_q.size() < cap) begin
      exp_q.push_back(pk(3'd1, 0, 0, 1, 0, 0, 1, 0, pc));
      exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 0, 1, 0, pc));
      op = mem[pc];
      pc = pc + 8'd1;
      exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 0, 1, 0, pc));
      case (op)
        8'h0B: begin
          exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 0, 0, 1, pc));
          fin = 1'b1;
        end
        8'h09, 8'h0A: begin
          exp_q.push_back(pk(3'd1, 0, 0, 1, 0, 0, 1, 0, pc));
          z = zseq[exp_q.size()];
          exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 0, 1, 0, pc));
          tgt = mem[pc];
          if (op == 8'h09 || !z) pc = tgt;
          else pc = pc + 8'd1;
        end
        8'h01: begin
          exp_q.push_back(pk(3'd1, 0, 0, 0, 1, 0, 1, 0, pc));
          exp_q.push_back(pk(3'd1, 1, 0, 0, 0, 0, 1, 0, pc));
        end
        8'h02: exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 1, 1, 0, pc));
        8'h03: exp_q.push_back(pk(3'd0, 1, 0, 0, 0, 0, 1, 0, pc));
        8'h04: exp_q.push_back(pk(3'd2, 1, 0, 0, 0, 0, 1, 0, pc));
        8'h05: exp_q.push_back(pk(3'd3, 1, 0, 0, 0, 0, 1, 0, pc));
        8'h06: begin
`ifdef CU_MUL_WAIT_EN
          exp_q.push_back(pk(3'd4, 0, 0, 0, 0, 0, 1, 0, pc));
`endif
          exp_q.push_back(pk(3'd4, 1, 0, 0, 0, 0, 1, 0, pc));
        end
        8'h07: exp_q.push_back(pk(3'd5, 1, 0, 0, 0, 0, 1, 0, pc));
        8'h08: exp_q.push_back(pk(3'd1, 0, 1, 0, 0, 0, 1, 0, pc));
        default: exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 0, 1, 0, pc));
      endcase
    end
    while (exp_q.size() > cap) void'(exp_q.pop_back());
  endtask

  // Starts the program, samples n cycles mid-cycle, then resets.
  task automatic run(input int n, input bit rnd_start);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start  = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      got[k] = cur();
      zFlag  = zseq[k];
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  vec_t idle0;
  vec_t mul3;
  vec_t mul4;

  initial begin
    nchk  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    zFlag = 1'b0;
    fill_end();
    idle0 = pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 8'h00);

    repeat (2) begin
      @(negedge clk);
      check("reset_state", cur(), idle0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", cur(), idle0);

`ifdef CU_MUL_WAIT_EN
    mul3 = pk(3'd4, 0, 0, 0, 0, 0, 1, 0, 8'h01);
    mul4 = pk(3'd4, 1, 0, 0, 0, 0, 1, 0, 8'h01);
`else
    mul3 = pk(3'd4, 1, 0, 0, 0, 0, 1, 0, 8'h01);
    mul4 = pk(3'd1, 0, 0, 1, 0, 0, 1, 0, 8'h01);
`endif

    tbl.push_back('{"first_fetch", 8'h04, 8'h0B, 0, 0, pk(1, 0, 0, 1, 0, 0, 1, 0, 8'h00)});
    tbl.push_back('{"add_exec", 8'h04, 8'h0B, 0, 3, pk(2, 1, 0, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"add_end_done", 8'h04, 8'h0B, 0, 7, pk(1, 0, 0, 0, 0, 0, 0, 1, 8'h02)});
    tbl.push_back('{"add_after_done", 8'h04, 8'h0B, 0, 8, pk(1, 0, 0, 0, 0, 0, 0, 0, 8'h02)});
    tbl.push_back('{"jpnz_taken", 8'h0A, 8'h05, 0, 5, pk(1, 0, 0, 1, 0, 0, 1, 0, 8'h05)});
    tbl.push_back('{"jpnz_not_taken", 8'h0A, 8'h05, 1, 5, pk(1, 0, 0, 1, 0, 0, 1, 0, 8'h02)});
    tbl.push_back('{"jump_ignores_z", 8'h09, 8'h80, 1, 5, pk(1, 0, 0, 1, 0, 0, 1, 0, 8'h80)});
    tbl.push_back('{"ldac_exec", 8'h01, 8'h0B, 0, 3, pk(1, 0, 0, 0, 1, 0, 1, 0, 8'h01)});
    tbl.push_back('{"ldac_memwait", 8'h01, 8'h0B, 0, 4, pk(1, 1, 0, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"ldac_next_fetch", 8'h01, 8'h0B, 0, 5, pk(1, 0, 0, 1, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"unknown_ff", 8'hFF, 8'h0B, 0, 3, pk(1, 0, 0, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"mvacr", 8'h08, 8'h0B, 0, 3, pk(1, 0, 1, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"stac", 8'h02, 8'h0B, 0, 3, pk(1, 0, 0, 0, 0, 1, 1, 0, 8'h01)});
    tbl.push_back('{"clac", 8'h03, 8'h0B, 0, 3, pk(0, 1, 0, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"sub", 8'h05, 8'h0B, 0, 3, pk(3, 1, 0, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"incac", 8'h07, 8'h0B, 0, 3, pk(5, 1, 0, 0, 0, 0, 1, 0, 8'h01)});
    tbl.push_back('{"mul_c3", 8'h06, 8'h0B, 0, 3, mul3});
    tbl.push_back('{"mul_c4", 8'h06, 8'h0B, 0, 4, mul4});
    tbl.push_back('{"pc_wrap_decode", 8'h09, 8'hFF, 0, 7, pk(1, 0, 0, 0, 0, 0, 1, 0, 8'h00)});
    tbl.push_back('{"pc_wrap_end", 8'h09, 8'hFF, 0, 8, pk(1, 0, 0, 0, 0, 0, 0, 1, 8'h00)});

    foreach (tbl[i]) begin
      fill_end();
      mem[0] = tbl[i].p0;
      mem[1] = tbl[i].p1;
      for (int k = 0; k < 512; k++) zseq[k] = tbl[i].z;
      run(tbl[i].cyc + 1, 1'b0);
      check(tbl[i].name, got[tbl[i].cyc], tbl[i].e);
    end

    // Reset during LDAC's EXEC: the memory-wait write must not happen.
    fill_end();
    mem[0] = 8'h01;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_ldac_exec", cur(), pk(1, 0, 0, 0, 1, 0, 1, 0, 8'h01));
    rst = 1'b1;
    @(negedge clk);
    check("rst_ldac_next", cur(), idle0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ldac_hold", cur(), idle0);

    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 256; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 8) mem[i] = 8'h0B;
        else if (r < 16) mem[i] = 8'h09;
        else if (r < 24) mem[i] = 8'h0A;
        else if (r < 30) mem[i] = 8'($urandom_range(12, 255));
        else mem[i] = 8'($urandom_range(0, 8));
      end
      for (int k = 0; k < 512; k++) zseq[k] = 1'($urandom_range(0, 1));
      build_model(100);
      run(exp_q.size(), 1'b1);
      foreach (exp_q[k])
        check($sformatf("rand_p%0d_c%0d", p, k), got[k], exp_q[k]);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
